// File: rtl/raw_data_packer.sv
// Gathers WORDS_PER_PACKET raw words into one wide packed word and pushes it to a
// downstream FIFO; partial packets leave on a flush request or an idle timeout.
module raw_data_packer #(
    parameter int DATA_WIDTH       = 32,
    parameter int WORDS_PER_PACKET = 4,
    parameter int CNT_WIDTH        = 3,
    parameter int PACKET_TIMEOUT   = 255
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   raw_data_valid,
    input  logic [DATA_WIDTH-1:0]                  raw_data,
    output logic                                   raw_data_accepted,
    input  logic                                   flush,
    input  logic                                   packed_data_in_fifo_full,
    output logic                                   packed_data_in_push,
    output logic [DATA_WIDTH*WORDS_PER_PACKET-1:0] packed_data,
    output logic [CNT_WIDTH-1:0]                   packed_word_count,
    output logic [3:0]                             fsm_state_o
);

    // Handshakes: the producer holds raw_data_valid and raw_data until it sees the
    // one-cycle raw_data_accepted pulse; a push happens in any cycle where
    // packed_data_in_push is 1, which is only while the FIFO reports not full.

    localparam int PW = DATA_WIDTH * WORDS_PER_PACKET;
    localparam logic [CNT_WIDTH-1:0] FULL_IDX     = CNT_WIDTH'(WORDS_PER_PACKET);
    localparam logic [15:0]          TIMEOUT_LAST = 16'(PACKET_TIMEOUT - 1);
    localparam bit                   TIMEOUT_EN   = (PACKET_TIMEOUT != 0);

    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        ACCEPT  = 4'b0010,
        HOLDOFF = 4'b0100,
        PUSH    = 4'b1000
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] index_q, index_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [15:0]          timer_q, timer_d;
    logic [PW-1:0]        packed_q, packed_d;
    logic                 accept_c, push_c;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            index_q  <= '0;
            count_q  <= '0;
            timer_q  <= '0;
            packed_q <= '0;
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            count_q  <= count_d;
            timer_q  <= timer_d;
            packed_q <= packed_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        count_d  = count_q;
        packed_d = packed_q;
        timer_d  = '0;
        accept_c = 1'b0;
        push_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (index_q != '0 && !raw_data_valid)
                    timer_d = (&timer_q) ? timer_q : timer_q + 16'd1;
                if (index_q == FULL_IDX)
                    state_d = PUSH;
                else if (raw_data_valid)
                    state_d = ACCEPT;
                else if (flush && index_q != '0)
                    state_d = PUSH;
                else if (TIMEOUT_EN && index_q != '0 && timer_q == TIMEOUT_LAST)
                    state_d = PUSH;
            end
            ACCEPT: begin
                accept_c = 1'b1;
                for (int i = 0; i < WORDS_PER_PACKET; i++) begin
                    if (index_q == CNT_WIDTH'(i))
                        packed_d[i*DATA_WIDTH +: DATA_WIDTH] = raw_data;
                end
                index_d = index_q + CNT_WIDTH'(1);
                count_d = index_q + CNT_WIDTH'(1);
                state_d = HOLDOFF;
            end
            HOLDOFF: begin
                state_d = (index_q == FULL_IDX) ? PUSH : IDLE;
            end
            PUSH: begin
                // Stalling here while full is what propagates backpressure upstream.
                push_c = !packed_data_in_fifo_full;
                if (!packed_data_in_fifo_full) begin
                    index_d  = '0;
                    count_d  = '0;
                    packed_d = '0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Gating with reset keeps both strobes low before the first reset edge lands.
    assign raw_data_accepted   = accept_c & reset;
    assign packed_data_in_push = push_c & reset;
    assign packed_data         = packed_q;
    assign packed_word_count   = count_q;
    assign fsm_state_o         = state_q;

endmodule

// File: tb/tb_raw_data_packer.sv
// Directed bench for raw_data_packer: hand-computed packets checked through a push
// scoreboard plus cycle-accurate latency checks on accept and push strobes.
module tb_raw_data_packer;

    localparam int DW  = 32;
    localparam int WPP = 4;
    localparam int CW  = 3;
    localparam int TO  = 10;
    localparam int PW  = DW * WPP;

    localparam logic [3:0] ST_IDLE = 4'b0001;
    localparam logic [3:0] ST_PUSH = 4'b1000;

    logic          clk = 1'b0;
    logic          reset;
    logic          raw_data_valid;
    logic [DW-1:0] raw_data;
    logic          raw_data_accepted;
    logic          flush;
    logic          fifo_full;
    logic          push;
    logic [PW-1:0] packed_data;
    logic [CW-1:0] packed_word_count;
    logic [3:0]    fsm_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [PW-1:0] exp_q[$];
    logic [CW-1:0] exp_cnt_q[$];
    logic [PW-1:0] mon_data;
    logic [CW-1:0] mon_cnt;

    raw_data_packer #(
        .DATA_WIDTH      (DW),
        .WORDS_PER_PACKET(WPP),
        .CNT_WIDTH       (CW),
        .PACKET_TIMEOUT  (TO)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .raw_data_valid          (raw_data_valid),
        .raw_data                (raw_data),
        .raw_data_accepted       (raw_data_accepted),
        .flush                   (flush),
        .packed_data_in_fifo_full(fifo_full),
        .packed_data_in_push     (push),
        .packed_data             (packed_data),
        .packed_word_count       (packed_word_count),
        .fsm_state_o             (fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Push monitor: samples after the drivers settle, compares against expected packets.
    always @(negedge clk) begin
        #1;
        if (push === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_push", push, 0);
            end else begin
                mon_data = exp_q.pop_front();
                mon_cnt  = exp_cnt_q.pop_front();
                check_eq("push_data", packed_data, mon_data);
                check_eq("push_count", packed_word_count, mon_cnt);
            end
        end
    end

    // Returns at the negedge of the HOLDOFF cycle following the accept.
    task automatic send_word(input logic [DW-1:0] d, output int waited);
        raw_data       = d;
        raw_data_valid = 1'b1;
        waited         = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (raw_data_accepted !== 1'b1 && waited < 40);
        check_eq("accept_seen", raw_data_accepted, 1);
        @(negedge clk);
        check_eq("accept_pulse", raw_data_accepted, 0);
        raw_data_valid = 1'b0;
    endtask

    task automatic expect_packet(input logic [PW-1:0] d, input logic [CW-1:0] c);
        exp_q.push_back(d);
        exp_cnt_q.push_back(c);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int k;
        logic [DW-1:0] words[4];

        reset          = 1'b0;
        raw_data_valid = 1'b1;
        raw_data       = 32'hDEAD_BEEF;
        flush          = 1'b0;
        fifo_full      = 1'b0;

        // Reset held two cycles with valid asserted.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("rst_accepted", raw_data_accepted, 0);
            check_eq("rst_push", push, 0);
            check_eq("rst_packed", packed_data, 0);
            check_eq("rst_count", packed_word_count, 0);
        end
        raw_data_valid = 1'b0;
        reset          = 1'b1;
        @(negedge clk);
        check_eq("post_rst_state", fsm_state, ST_IDLE);
        check_eq("post_rst_accepted", raw_data_accepted, 0);

        // Full packet, no backpressure.
        words = '{32'h11, 32'h22, 32'h33, 32'h44};
        expect_packet(128'h00000044_00000033_00000022_00000011, 3'd4);
        for (int i = 0; i < 4; i++) begin
            send_word(words[i], w);
            check_eq("accept_spacing", w, (i == 0) ? 1 : 2);
        end
        check_eq("count_full", packed_word_count, 4);
        @(negedge clk);
        check_eq("push_latency", push, 1);
        @(negedge clk);
        check_eq("after_push_push", push, 0);
        check_eq("after_push_count", packed_word_count, 0);
        check_eq("after_push_packed", packed_data, 0);

        // Two words then a one-cycle flush.
        expect_packet(128'h0000000B_0000000A, 3'd2);
        send_word(32'hA, w);
        check_eq("flush_w0_lat", w, 1);
        send_word(32'hB, w);
        check_eq("flush_count", packed_word_count, 2);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_eq("flush_push", push, 1);
        @(negedge clk);
        check_eq("flush_after_push", push, 0);

        // Flush with an empty packet is ignored.
        flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("empty_flush_push", push, 0);
            check_eq("empty_flush_state", fsm_state, ST_IDLE);
        end
        flush = 1'b0;

        // Idle timeout with one word: 10 idle cycles, then the push cycle.
        expect_packet(128'h5, 3'd1);
        send_word(32'h5, w);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (push !== 1'b1 && k < 30);
        check_eq("timeout_latency", k, 11);
        @(negedge clk);
        check_eq("timeout_after_count", packed_word_count, 0);

        // Valid re-asserted in idle cycle 9 restarts the timer.
        expect_packet(128'h00000007_00000006, 3'd2);
        send_word(32'h6, w);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check_eq("timer_pre_push", push, 0);
        end
        send_word(32'h7, w);
        check_eq("timer_reassert_lat", w, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("timer_restart_push", push, 0);
        end
        @(negedge clk);
        check_eq("timer_restart_fire", push, 1);
        @(negedge clk);

        // Backpressure: full packet held 20 cycles while the next word waits.
        fifo_full = 1'b1;
        words = '{32'h100, 32'h101, 32'h102, 32'h103};
        expect_packet(128'h00000103_00000102_00000101_00000100, 3'd4);
        for (int i = 0; i < 4; i++) send_word(words[i], w);
        raw_data       = 32'h200;
        raw_data_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("bp_push", push, 0);
            check_eq("bp_accepted", raw_data_accepted, 0);
        end
        check_eq("bp_state", fsm_state, ST_PUSH);
        fifo_full = 1'b0;
        #1;
        check_eq("bp_release_push", push, 1);
        @(negedge clk);
        check_eq("bp_next_acc_early", raw_data_accepted, 0);
        @(negedge clk);
        check_eq("bp_next_acc", raw_data_accepted, 1);
        @(negedge clk);
        raw_data_valid = 1'b0;
        check_eq("bp_next_count", packed_word_count, 1);

        // Partial packet of three discarded by reset; fresh packet afterwards.
        send_word(32'h201, w);
        send_word(32'h202, w);
        check_eq("partial_count", packed_word_count, 3);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_eq("midrst_push", push, 0);
        check_eq("midrst_count", packed_word_count, 0);
        check_eq("midrst_packed", packed_data, 0);
        check_eq("midrst_state", fsm_state, ST_IDLE);
        words = '{32'h301, 32'h302, 32'h303, 32'h304};
        expect_packet(128'h00000304_00000303_00000302_00000301, 3'd4);
        for (int i = 0; i < 4; i++) send_word(words[i], w);
        @(negedge clk);
        check_eq("fresh_push", push, 1);
        @(negedge clk);
        @(negedge clk);

        check_eq("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/raw_data_packer.md
Name: raw_data_packer

Overview:
- Consumer end of the raw_data_valid / raw_data_accepted handshake. Takes single raw words from an upstream producer FSM and gathers WORDS_PER_PACKET of them into one wide packed word.
- Pushes each packed word into a downstream packed-data FIFO.
- Flushes partial packets on an explicit flush request or an idle timeout.

Parameters:
DATA_WIDTH, 32, width of one raw word
WORDS_PER_PACKET, 4, raw words per packed word (>=2)
CNT_WIDTH, 3, width of word index/count; must hold WORDS_PER_PACKET
PACKET_TIMEOUT, 255, idle cycles before a partial packet is flushed; 0 disables timeout (16-bit max)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous active-low reset (0 = reset)
raw_data_valid  input  1  producer has a word on raw_data
raw_data  input  DATA_WIDTH  raw word; stable while raw_data_valid=1 until accepted
raw_data_accepted  output  1  one-cycle pulse: raw_data captured this cycle
flush  input  1  level request to emit a partial packet
packed_data_in_fifo_full  input  1  downstream FIFO full
packed_data_in_push  output  1  push strobe to downstream FIFO
packed_data  output  DATA_WIDTH*WORDS_PER_PACKET  packed word; word 0 in LSBs, unfilled slots zero
packed_word_count  output  CNT_WIDTH  number of valid words in packed_data

Behaviour:
- Reset (reset=0 at a clock edge):
  - state=IDLE; index=0; timer=0; packed_data=0; packed_word_count=0.
  - raw_data_accepted=0 and packed_data_in_push=0 during and after reset.
  - A partial packet present at reset is discarded without a push.
- States are one-hot: IDLE, ACCEPT, HOLDOFF, PUSH.
- IDLE (accepted=0, push=0). Exit conditions, checked in priority order:
  - index==WORDS_PER_PACKET -> PUSH.
  - Else raw_data_valid=1 -> ACCEPT.
  - Else flush=1 and index>0 -> PUSH.
  - Else PACKET_TIMEOUT!=0, index>0 and timer==PACKET_TIMEOUT-1 -> PUSH.
  - Else stay in IDLE.
- ACCEPT:
  - raw_data_accepted=1 for exactly this cycle.
  - At the closing edge: slot[index] <= raw_data; index <= index+1; packed_word_count <= index+1.
  - Always -> HOLDOFF.
- HOLDOFF:
  - accepted=0, giving the producer one cycle to drop or refresh valid.
  - raw_data_valid is ignored in this state.
  - -> PUSH if index==WORDS_PER_PACKET, else IDLE.
- PUSH:
  - packed_data_in_push = ~packed_data_in_fifo_full. This output is combinational on full; packed_data is registered and stable.
  - If not full: the push occurs. At the edge, index, packed_data and packed_word_count clear to 0 -> IDLE.
  - If full: stay in PUSH, push=0, hold contents. No raw word is accepted while in PUSH (backpressure reaches upstream).
- Timer:
  - 16-bit. Increments each IDLE cycle with index>0 and raw_data_valid=0.
  - Clears to 0 in any other state/condition, including when valid=1 or index==0.
  - Saturates; never wraps.
- Latency:
  - Valid rising in IDLE at cycle n -> accepted at cycle n+1.
  - Full packet (last word accepted at cycle m) -> push earliest at cycle m+2.
  - Sustained throughput: 1 raw word per 3 cycles.
- Simultaneous events:
  - valid and flush together in IDLE: the word is accepted first. The flush is taken on a later IDLE cycle if still asserted.
  - flush with index==0 is ignored; no empty push is ever issued.
- Illegal state encodings -> IDLE next cycle. index is not modified on this transition.

Test Plan:
- Reset with reset=0 for 2 cycles while raw_data_valid=1 -> accepted=0, push=0, packed_data=0, count=0 throughout.
- Four words 0x11,0x22,0x33,0x44, each valid held until accepted, FIFO not full -> four single-cycle accepted pulses spaced 3 cycles apart; one push with packed_data=0x00000044_00000033_00000022_00000011 and count=4, issued 2 cycles after the 4th accept.
- Two words 0xA,0xB, then flush=1 for 1 cycle -> push with packed_data=0x...0000000B_0000000A (upper slots zero) and count=2.
- PACKET_TIMEOUT=10, one word 0x5 then valid=0 -> push occurs exactly 10 idle cycles after HOLDOFF, count=1. Repeat with valid re-asserted at idle cycle 9 -> timer clears, no push until a full packet or a new timeout.
- Full packet ready with fifo_full=1 for 20 cycles, valid held high -> push=0 and accepted=0 for 20 cycles; push fires in the cycle full drops; the next word is accepted 2 cycles after that push.
- Three words captured, then reset=0 for 1 cycle -> no push; next 4 words form a fresh packet with count=4 and no stale data.
